// File: rtl/cory_arb8_pkg.sv
// Shared types and the round-robin pick helper for the eight-way arbiter.
package cory_arb8_pkg;

  localparam int CORY_ARB8_NREQ = 8;
  localparam int CORY_ARB8_IDXW = 3;

  typedef logic [CORY_ARB8_IDXW-1:0] idx_t;

  typedef struct packed {
    logic any;
    idx_t winner;
  } pick_t;

  // First set request scanning ptr, ptr+1, ... wrapping mod 8.
  function automatic pick_t rr_pick(input logic [CORY_ARB8_NREQ-1:0] req, input idx_t ptr);
    pick_t res;
    idx_t  idx;
    res.any    = 1'b0;
    res.winner = idx_t'(0);
    for (int i = CORY_ARB8_NREQ - 1; i >= 0; i--) begin
      idx = ptr + idx_t'(i);
      if (req[idx]) begin
        res.any    = 1'b1;
        res.winner = idx;
      end else begin
        res.any    = res.any;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cory_arb8_tagq.sv
// In-order FIFO of 3-bit source indices; a pop in the same cycle does not make room for a push.
module cory_arb8_tagq
  import cory_arb8_pkg::*;
#(
  parameter int D = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  idx_t push_d,
  input  logic pop,
  output logic head_v,
  output idx_t head_d,
  output logic full
);

  localparam int AW = $clog2(D);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(D);
  localparam logic [AW:0]   CNT_ONE_C = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  idx_t          mem_r [D];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify push/pop against the registered occupancy.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (push && (count_r != DEPTH_C)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && (count_r != '0)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < D; i++) begin
        mem_r[i] <= idx_t'(0);
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_d;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_v = (count_r != '0);
  assign head_d = mem_r[rd_ptr_r];
  assign full   = (count_r == DEPTH_C);

endmodule

// File: rtl/cory_arb8.sv
// Eight-input round-robin arbiter with a registered merged output and an in-order source-tag stream.
module cory_arb8
  import cory_arb8_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   i_mask,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  output logic         o_a1_r,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  output logic         o_a2_r,
  input  logic         i_a3_v,
  input  logic [N-1:0] i_a3_d,
  output logic         o_a3_r,
  input  logic         i_a4_v,
  input  logic [N-1:0] i_a4_d,
  output logic         o_a4_r,
  input  logic         i_a5_v,
  input  logic [N-1:0] i_a5_d,
  output logic         o_a5_r,
  input  logic         i_a6_v,
  input  logic [N-1:0] i_a6_d,
  output logic         o_a6_r,
  input  logic         i_a7_v,
  input  logic [N-1:0] i_a7_d,
  output logic         o_a7_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  input  logic         i_z_r,
  output logic         o_s_v,
  output logic [2:0]   o_s_d,
  input  logic         i_s_r
);

  logic [CORY_ARB8_NREQ-1:0] req_v_s;
  logic [N-1:0]              req_d_s [CORY_ARB8_NREQ];
  logic [CORY_ARB8_NREQ-1:0] elig_s;
  logic [CORY_ARB8_NREQ-1:0] ack_s;
  pick_t                     pick_s;
  logic                      z_free_s;
  logic                      tag_full_s;
  logic                      grant_s;
  logic                      pop_s;
  logic [N-1:0]              win_d_s;
  logic                      tag_v_s;
  idx_t                      tag_d_s;

  logic                      z_v_r;
  logic [N-1:0]              z_d_r;
  idx_t                      ptr_r;

  assign req_v_s = {i_a7_v, i_a6_v, i_a5_v, i_a4_v, i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign req_d_s[0] = i_a0_d;
  assign req_d_s[1] = i_a1_d;
  assign req_d_s[2] = i_a2_d;
  assign req_d_s[3] = i_a3_d;
  assign req_d_s[4] = i_a4_d;
  assign req_d_s[5] = i_a5_d;
  assign req_d_s[6] = i_a6_d;
  assign req_d_s[7] = i_a7_d;

  // Arbitration: the reset gate keeps every accept low while reset_n is asserted.
  always_comb begin
    elig_s   = req_v_s & ~i_mask;
    pick_s   = rr_pick(elig_s, ptr_r);
    z_free_s = ~z_v_r | i_z_r;
    grant_s  = z_free_s & ~tag_full_s & pick_s.any & reset_n;
    win_d_s  = req_d_s[pick_s.winner];
    if (grant_s) begin
      ack_s = 8'h01 << pick_s.winner;
    end else begin
      ack_s = 8'h00;
    end
  end

  assign {o_a7_r, o_a6_r, o_a5_r, o_a4_r, o_a3_r, o_a2_r, o_a1_r, o_a0_r} = ack_s;

  // Output register and round-robin pointer; data holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_v_r <= 1'b0;
      z_d_r <= '0;
      ptr_r <= idx_t'(0);
    end else if (grant_s) begin
      z_v_r <= 1'b1;
      z_d_r <= win_d_s;
      ptr_r <= pick_s.winner + idx_t'(1);
    end else if (z_v_r && i_z_r) begin
      z_v_r <= 1'b0;
    end else begin
      z_v_r <= z_v_r;
    end
  end

  assign pop_s = tag_v_s & i_s_r;

  cory_arb8_tagq #(
    .D(D)
  ) u_tagq (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (grant_s),
    .push_d (pick_s.winner),
    .pop    (pop_s),
    .head_v (tag_v_s),
    .head_d (tag_d_s),
    .full   (tag_full_s)
  );

  assign o_z_v = z_v_r;
  assign o_z_d = z_d_r;
  assign o_s_v = tag_v_s;
  assign o_s_d = tag_d_s;

endmodule

// File: doc/cory_arb8.md
# cory_arb8

Round-robin arbiter that merges eight valid/ready request streams onto one registered output stream. For every granted transfer it pushes the 3-bit source index into an in-order tag FIFO, exposed as a select stream that can drive the select port of an 8-way demultiplexer on the return path. Sits in front of a shared resource (memory port, bus master) used by up to eight requesters.

## Interface
- N, 8, data width
- D, 4, tag FIFO depth (power of 2, ≥2); limits outstanding un-acknowledged transfers
- clk  in  1  clock, all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- i_mask  in  8  bit k=1 excludes requester k from arbitration; sampled every cycle
- i_ak_v  in  1  (k=0..7) request k valid
- i_ak_d  in  N  (k=0..7) request k data
- o_ak_r  out  1  (k=0..7) request k accepted this cycle
- o_z_v  out  1  merged output valid
- o_z_d  out  N  merged output data
- i_z_r  in  1  merged output ready
- o_s_v  out  1  tag FIFO head valid
- o_s_d  out  3  source index of oldest un-popped transfer
- i_s_r  in  1  pop tag FIFO head

## Operation
- Registers: ptr[2:0] (RR start), z_v/z_d output register, tag FIFO (count 0..D).
- z_free = !o_z_v || i_z_r; tag_free = count < D (a same-cycle pop does not free a slot).
- Eligible k: i_ak_v && !i_mask[k]. Winner: first eligible k scanning ptr, ptr+1, …, ptr+7 mod 8.
- Grant when z_free && tag_free && any eligible && reset_n: o_a[winner]_r=1, all other o_ak_r=0; z_d <= i_a[winner]_d, z_v <= 1; push winner into tag FIFO; ptr <= winner+1 mod 8 (7 wraps to 0).
- No grant: all o_ak_r=0, ptr unchanged; z_v <= 0 if o_z_v && i_z_r, else hold.
- Output register holds o_z_d stable while o_z_v && !i_z_r.
- Tag FIFO: push on grant, pop on o_s_v && i_s_r; simultaneous push+pop keeps count; order strictly preserved; o_s_d = head entry.
- The tag stream is independent of the z stream: tags may be popped before or after the matching z beat.
- Mask change takes effect on the same cycle's arbitration; already-registered data is unaffected.

## Timing
- Reset (reset_n=0 at an edge): o_z_v=0, o_z_d=0, o_s_v=0, o_s_d=0, ptr=0, count=0. While reset_n=0 all o_ak_r=0 (combinational gate). Reset mid-transfer discards the output register and all tags.
- o_ak_r is combinational from i_ak_v, i_mask, i_z_r, and registered state (path i_z_r -> o_ak_r exists).
- Latency: grant at edge t -> o_z_v=1 and o_s_v=1 from t+1. Full throughput of 1 transfer/cycle while i_z_r=1 and tags are popped.
- Tag FIFO empty: o_s_v=0, no push-to-pop bypass. Tag FIFO full (count=D): no grants until a pop has been registered, i.e. one bubble cycle after the pop.
- Output stall: o_z_v=1, i_z_r=0 -> no grant; ptr frozen.

## Structure
- Shared package: CORY_ARB8_NREQ=8, index width 3, round-robin pick function (8-bit request, 3-bit ptr -> 1-bit any, 3-bit winner).
- Sub-module cory_arb8_tagq: D-entry, 3-bit synchronous FIFO with push/pop/count; synchronous active-low reset on clk/reset_n.
- Top contains: arbitration logic, ptr, output register.

## Test plan
- All eight valid, i_z_r=1, i_s_r=1, mask=0 -> grants 0,1,…,7,0 on consecutive cycles; o_s_d sequence matches; o_z_d follows.
- Only requesters 2 and 5 valid, ptr=0 -> grants 2,5,2,5; after granting 7, ptr wraps to 0.
- i_mask=8'h01 with all valid -> requester 0 never granted; clearing the mask -> 0 is granted once ptr passes it.
- i_s_r=0, D=4 -> exactly 4 grants, then all o_ak_r=0; one pop -> the next grant occurs on the cycle after the pop.
- i_z_r=0 with o_z_v=1 -> o_z_d stable and no grants; when i_z_r rises, the next grant occurs in the same cycle.
- reset_n low for one cycle mid-stream with 3 tags queued -> o_z_v=0, o_s_v=0, and the first grant after reset is the lowest eligible index from 0.
